// File: rtl/cpu_mem_pkg.sv
// Shared constants and enums for the CPU memory responder.
package cpu_mem_pkg;

    localparam int                    CPU_ADDR_W    = 13;
    localparam int                    CPU_DATA_W    = 8;
    localparam int                    CPU_ROM_DEPTH = 6144;
    localparam logic [CPU_ADDR_W-1:0] CPU_RAM_BASE  = 13'h1800;
    localparam int                    CPU_RAM_DEPTH = 256;

    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_NONE} region_e;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_HOLD} state_e;

endpackage

// File: rtl/cpu_mem_ram.sv
// Synchronous-write, asynchronous-read 1R1W storage array.
// The top widens WIDTH by one parity bit when CPU_MEM_PARITY_EN is defined.
module cpu_mem_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single-port write; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: ROM/RAM decode, wait-stated reads, one write per
// wr pulse, sticky error flags.
// Optional: CPU_MEM_PARITY_EN adds an even-parity bit per RAM word and the
// err_parity output.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int                ADDR_W      = CPU_ADDR_W,
    parameter int                DATA_W      = CPU_DATA_W,
    parameter int                ROM_DEPTH   = CPU_ROM_DEPTH,
    parameter logic [ADDR_W-1:0] RAM_BASE    = CPU_RAM_BASE,
    parameter int                RAM_DEPTH   = CPU_RAM_DEPTH,
    parameter int                WAIT_STATES = 0,
    parameter string             ROM_INIT    = "rom.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic              wr,
    input  logic              datacontrol_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err_rom_wr,
    output logic              err_oob,
    output logic              err_conflict
`ifdef CPU_MEM_PARITY_EN
    ,
    output logic              err_parity
`endif
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
`ifdef CPU_MEM_PARITY_EN
    localparam int RAM_W  = DATA_W + 1;
`else
    localparam int RAM_W  = DATA_W;
`endif

    // Plain unsigned range checks, widened to 32 bits so nothing wraps.
    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        if (32'(a) < 32'(ROM_DEPTH))
            return REG_ROM;
        if (32'(a) >= 32'(RAM_BASE) && 32'(a) < 32'(RAM_BASE) + 32'(RAM_DEPTH))
            return REG_RAM;
        return REG_NONE;
    endfunction

    logic [DATA_W-1:0] rom [ROM_DEPTH];

    state_e            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        cnt;
    logic              start_rd, load_rd, ram_we;
    logic              ev_rom_wr, ev_oob_wr, ev_oob_rd, ev_conflict;
    logic [ADDR_W-1:0] raddr;
    region_e           rreg, wreg;
    logic [RAM_W-1:0]  ram_rd, ram_wd;
    logic [DATA_W-1:0] load_data;
`ifdef CPU_MEM_PARITY_EN
    logic              ev_parity;
`endif

    // A zero-wait read completes on the request edge, so it must see the
    // live address; later completions use the latched one.
    assign raddr = (state == IDLE) ? addr : addr_q;
    assign rreg  = decode(raddr);
    assign wreg  = decode(addr);

`ifdef CPU_MEM_PARITY_EN
    assign ram_wd = {^wdata, wdata};
`else
    assign ram_wd = wdata;
`endif

    cpu_mem_ram #(
        .WIDTH (RAM_W),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (RAM_AW'(addr - RAM_BASE)),
        .wdata (ram_wd),
        .raddr (RAM_AW'(raddr - RAM_BASE)),
        .rdata (ram_rd)
    );

    // Next state, strobe qualification and error events.
    always_comb begin
        state_nx    = state;
        start_rd    = 1'b0;
        load_rd     = 1'b0;
        ram_we      = 1'b0;
        ev_rom_wr   = 1'b0;
        ev_oob_wr   = 1'b0;
        ev_conflict = 1'b0;
        case (state)
            IDLE: begin
                if (rd && wr) begin
                    ev_conflict = 1'b1;
                end else if (rd) begin
                    start_rd = 1'b1;
                    if (WAIT_STATES == 0) begin
                        load_rd  = 1'b1;
                        state_nx = RD_DONE;
                    end else begin
                        state_nx = RD_WAIT;
                    end
                end else if (wr && !datacontrol_en) begin
                    ev_conflict = 1'b1;
                end else if (wr) begin
                    state_nx = WR_HOLD;
                    case (wreg)
                        REG_RAM: ram_we    = rst_n;  // no write while held in reset
                        REG_ROM: ev_rom_wr = 1'b1;
                        default: ev_oob_wr = 1'b1;
                    endcase
                end
            end
            RD_WAIT: begin
                if (!rd) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd1) begin
                    load_rd  = 1'b1;
                    state_nx = RD_DONE;
                end
            end
            RD_DONE: if (!rd) state_nx = IDLE;
            WR_HOLD: if (!wr) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data selection by region of the completing address.
    always_comb begin
        load_data = '0;
        ev_oob_rd = 1'b0;
`ifdef CPU_MEM_PARITY_EN
        ev_parity = 1'b0;
`endif
        case (rreg)
            REG_ROM: load_data = rom[ROM_AW'(raddr)];
            REG_RAM: begin
                load_data = ram_rd[DATA_W-1:0];
`ifdef CPU_MEM_PARITY_EN
                ev_parity = ^ram_rd;
`endif
            end
            default: ev_oob_rd = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Request address latch and wait-state down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt    <= '0;
        end else if (start_rd) begin
            addr_q <= addr;
            cnt    <= 4'(WAIT_STATES);
        end else if (state == RD_WAIT) begin
            cnt    <= cnt - 4'd1;
        end
    end

    // Read data register, held until the next completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata <= '0;
        else if (load_rd) rdata <= load_data;
    end

    // Sticky error flags; a same-cycle event wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_rom_wr   <= 1'b0;
            err_oob      <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            err_rom_wr   <= (err_rom_wr   & ~err_clr) | ev_rom_wr;
            err_oob      <= (err_oob      & ~err_clr) | ev_oob_wr | (load_rd & ev_oob_rd);
            err_conflict <= (err_conflict & ~err_clr) | ev_conflict;
        end
    end

`ifdef CPU_MEM_PARITY_EN
    // Sticky parity flag, raised by any completed RAM read with bad parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_parity <= 1'b0;
        else        err_parity <= (err_parity & ~err_clr) | (load_rd & ev_parity);
    end
`endif

    assign rvalid = (state == RD_DONE);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (0 and 3 wait states) share
// one stimulus stream; a transaction-level model predicts every output.
module tb_cpu_mem_responder;

    localparam int          ROMD = 6144;
    localparam int          RAMD = 256;
    localparam logic [12:0] RAMB = 13'h1800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        rd = 1'b0, wr = 1'b0, datacontrol_en = 1'b0, err_clr = 1'b0;

    logic [7:0]  rdata_o [2];
    logic        rvalid_o [2], busy_o [2], erw_o [2], eoob_o [2], ecf_o [2];
`ifdef CPU_MEM_PARITY_EN
    logic        epar_o [2];
`endif

    always #5 clk = ~clk;

    cpu_mem_responder #(.WAIT_STATES(0), .ROM_INIT("")) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .datacontrol_en(datacontrol_en), .err_clr(err_clr),
        .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .busy(busy_o[0]),
        .err_rom_wr(erw_o[0]), .err_oob(eoob_o[0]), .err_conflict(ecf_o[0])
`ifdef CPU_MEM_PARITY_EN
        , .err_parity(epar_o[0])
`endif
    );

    cpu_mem_responder #(.WAIT_STATES(3), .ROM_INIT("")) dut3 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .datacontrol_en(datacontrol_en), .err_clr(err_clr),
        .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .busy(busy_o[1]),
        .err_rom_wr(erw_o[1]), .err_oob(eoob_o[1]), .err_conflict(ecf_o[1])
`ifdef CPU_MEM_PARITY_EN
        , .err_parity(epar_o[1])
`endif
    );

    // Reference model state
    logic [7:0] tb_rom [ROMD];
    logic [7:0] tb_ram [RAMD];
    bit         par_bad [RAMD];
    int         ws [2];
    logic [7:0] m_rdata [2];
    bit         m_rw [2], m_oob [2], m_cf [2], m_par [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[ws%0d]: observed %0h expected %0h", tag, ws[i], obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model(input int i);
        m_rw[i] = 0; m_oob[i] = 0; m_cf[i] = 0; m_par[i] = 0;
    endtask

    function automatic logic [12:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 4) return 13'($urandom_range(0, ROMD - 1));
        if (r < 8) return RAMB + 13'($urandom_range(0, RAMD - 1));
        return 13'($urandom_range(32'h1900, 32'h1FFF));
    endfunction

    // Region lookup straight from the memory map.
    task automatic lookup(input logic [12:0] a, output logic [7:0] v, output bit oob, output bit bad);
        v = 8'h00; oob = 0; bad = 0;
        if (int'(a) < ROMD) begin
            v = tb_rom[a];
        end else if (a >= RAMB && int'(a) < int'(RAMB) + RAMD) begin
            v   = tb_ram[8'(a - RAMB)];
            bad = par_bad[8'(a - RAMB)];
        end else begin
            oob = 1;
        end
    endtask

    task automatic check_idle();
        for (int i = 0; i < 2; i++) begin
            check("rvalid_idle", i, 32'(rvalid_o[i]), 32'(0));
            check("busy_idle",   i, 32'(busy_o[i]),   32'(0));
            check("rdata_hold",  i, 32'(rdata_o[i]),  32'(m_rdata[i]));
            check("err_rom_wr",  i, 32'(erw_o[i]),    32'(m_rw[i]));
            check("err_oob",     i, 32'(eoob_o[i]),   32'(m_oob[i]));
            check("err_conf",    i, 32'(ecf_o[i]),    32'(m_cf[i]));
`ifdef CPU_MEM_PARITY_EN
            check("err_parity",  i, 32'(epar_o[i]),   32'(m_par[i]));
`endif
        end
    endtask

    // rd held for 'hold' edges; a read completes only if hold reaches ws+1.
    task automatic do_read(input logic [12:0] a, input int hold);
        logic [7:0] v;
        bit oob, bad;
        lookup(a, v, oob, bad);
        addr = a; rd = 1; wr = 0; datacontrol_en = 0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (k == 1) addr = 13'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (k == ws[i] + 1) begin
                    m_rdata[i] = v;
                    if (oob) m_oob[i] = 1;
`ifdef CPU_MEM_PARITY_EN
                    if (bad) m_par[i] = 1;
`endif
                end
                check("rvalid", i, 32'(rvalid_o[i]), 32'(k >= ws[i] + 1));
                check("busy_rd", i, 32'(busy_o[i]), 32'(1));
                if (k >= ws[i] + 1) check("rdata", i, 32'(rdata_o[i]), 32'(m_rdata[i]));
            end
        end
        rd = 0;
        tick();
        check_idle();
    endtask

    // wr held for 'len' edges; only the first edge may commit.
    task automatic do_write(input logic [12:0] a, input logic [7:0] d, input int len,
                            input bit dce, input bit clr);
        addr = a; wdata = d; wr = 1; datacontrol_en = dce; err_clr = clr;
        tick();
        for (int i = 0; i < 2; i++) begin
            if (clr) clear_model(i);
            if (!dce) m_cf[i] = 1;
            else if (int'(a) < ROMD) m_rw[i] = 1;
            else if (a >= RAMB && int'(a) < int'(RAMB) + RAMD) ;
            else m_oob[i] = 1;
        end
        if (dce && a >= RAMB && int'(a) < int'(RAMB) + RAMD) begin
            tb_ram[8'(a - RAMB)]  = d;
            par_bad[8'(a - RAMB)] = 0;
        end
        err_clr = 0;
        wdata = ~d;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) tick();
            for (int i = 0; i < 2; i++) check("busy_wr", i, 32'(busy_o[i]), 32'(dce));
        end
        wr = 0; datacontrol_en = 0;
        tick();
        check_idle();
    endtask

    task automatic do_conflict(input logic [12:0] a, input int len);
        addr = a; wdata = 8'($urandom); rd = 1; wr = 1; datacontrol_en = 1'($urandom);
        for (int k = 1; k <= len; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                m_cf[i] = 1;
                check("busy_cf", i, 32'(busy_o[i]), 32'(0));
            end
        end
        rd = 0; wr = 0; datacontrol_en = 0;
        tick();
        check_idle();
    endtask

    task automatic do_clear();
        err_clr = 1;
        tick();
        err_clr = 0;
        for (int i = 0; i < 2; i++) clear_model(i);
        check_idle();
    endtask

    initial begin
        ws[0] = 0; ws[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_rdata[i] = 8'h00;
            clear_model(i);
        end

        // Asynchronous reset with no clock edge
        #1 rst_n = 0;
        #1;
        check_idle();

        for (int j = 0; j < ROMD; j++) begin
            tb_rom[j] = 8'($urandom);
            if (j == 5) tb_rom[j] = 8'hA5;
            dut0.rom[j] = tb_rom[j];
            dut3.rom[j] = tb_rom[j];
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        check_idle();

        // Give every RAM word a known value
        for (int j = 0; j < RAMD; j++)
            do_write(RAMB + 13'(j), 8'($urandom), $urandom_range(1, 3), 1, 0);

        // ROM read, then RAM write/readback with a long wr pulse
        do_read(13'h0005, 5);
        do_write(13'h1800, 8'h3C, 3, 1, 0);
        do_read(13'h1800, 5);

        // Illegal accesses and clear
        do_write(13'h0010, 8'h77, 1, 1, 0);
        do_read(13'h0010, 5);
        do_read(13'h1F00, 5);
        do_clear();

        // Region boundaries
        do_read(13'h17FF, 5);
        do_read(13'h18FF, 5);
        do_read(13'h1900, 5);
        do_write(13'h1900, 8'h11, 2, 1, 0);
        do_clear();

        // Abort: completes with no wait states, aborts with three
        do_read(13'h1801, 2);
        do_read(13'h0005, 4);
        do_read(13'h1802, 1);

        // Conflicts, then event and err_clr in the same cycle
        do_conflict(13'h1803, 2);
        do_write(13'h1804, 8'h5A, 2, 0, 0);
        do_read(13'h1803, 5);
        do_read(13'h1804, 5);
        do_write(13'h0020, 8'h01, 1, 1, 1);

        // Reset during RD_WAIT; a write attempted under reset must not land
        addr = 13'h0005; rd = 1;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_rdata[i] = 8'h00;
            clear_model(i);
        end
        check_idle();
        rd = 0; wr = 1; datacontrol_en = 1; addr = RAMB + 13'd7; wdata = ~tb_ram[7];
        tick();
        tick();
        wr = 0; datacontrol_en = 0;
        #2 rst_n = 1;
        tick();
        check_idle();
        do_read(RAMB + 13'd7, 5);

`ifdef CPU_MEM_PARITY_EN
        dut0.u_ram.mem[0][8] = ~dut0.u_ram.mem[0][8];
        dut3.u_ram.mem[0][8] = ~dut3.u_ram.mem[0][8];
        par_bad[0] = 1;
        do_read(RAMB, 5);
        do_clear();
`endif

        // Randomized transaction mix
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 8))
                0, 1, 2, 3: do_read(rand_addr(), $urandom_range(1, 6));
                4, 5, 6:    do_write(rand_addr(), 8'($urandom), $urandom_range(1, 3),
                                     $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
                7:          do_conflict(rand_addr(), $urandom_range(1, 2));
                default:    do_clear();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
